// File: rtl/bf_data_port.sv
// bf_data_port: turns Brainfuck data commands into req/ack memory transactions and owns the data pointer.
// Optional BF_DATA_CELL_CACHE_EN: remember that rdata mirrors the current cell and skip redundant reads.
`ifndef DIRECTION_READ
`define DIRECTION_READ 1'b0
`endif
`ifndef DIRECTION_WRITE
`define DIRECTION_WRITE 1'b1
`endif

module bf_data_port #(
    parameter int unsigned d_addr_width = 8,
    parameter int unsigned d_mem_length = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    input  logic [2:0]              cmd_op,
    input  logic [7:0]              cmd_wdata,
    output logic                    cmd_ready,
    output logic                    done,
    output logic [7:0]              rdata,
    output logic                    cell_zero,
    output logic [d_addr_width-1:0] dptr,
    output logic                    d_req,
    output logic                    d_dir,
    output logic [d_addr_width-1:0] d_addr,
    output logic [7:0]              d_wdata,
    input  logic                    d_ack,
    input  logic [7:0]              d_rdata
);

    typedef enum logic [2:0] {IDLE, RD, GAP, WR, FIN} state_t;

    localparam logic [2:0] OP_INC   = 3'd0;
    localparam logic [2:0] OP_DEC   = 3'd1;
    localparam logic [2:0] OP_RIGHT = 3'd2;
    localparam logic [2:0] OP_LEFT  = 3'd3;
    localparam logic [2:0] OP_LOAD  = 3'd4;
    localparam logic [2:0] OP_STORE = 3'd5;
    localparam logic [2:0] OP_NOP   = 3'd6;

    localparam logic [d_addr_width-1:0] PTR_ONE  = d_addr_width'(1);
    localparam logic [d_addr_width-1:0] PTR_LAST = d_addr_width'(d_mem_length - 1);

    state_t                  state, state_nxt;
    logic [2:0]              op, op_nxt;
    logic [d_addr_width-1:0] dptr_nxt, d_addr_nxt;
    logic [7:0]              rdata_nxt, d_wdata_nxt;
    logic                    d_req_nxt, d_dir_nxt, done_nxt;
    logic                    accept, cache_hit;

    // 8-bit wrapping increment/decrement of a cell value
    function automatic logic [7:0] cell_step(input logic [7:0] v, input logic down);
        return down ? v - 8'd1 : v + 8'd1;
    endfunction

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign cell_zero = (rdata == 8'd0);

`ifdef BF_DATA_CELL_CACHE_EN
    logic cache_valid;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cache_valid <= 1'b0;
        else if (accept && (cmd_op == OP_RIGHT || cmd_op == OP_LEFT))
            cache_valid <= 1'b0;
        else if (state == FIN &&
                 (op == OP_INC || op == OP_DEC || op == OP_LOAD || op == OP_STORE))
            cache_valid <= 1'b1;
    end

    assign cache_hit = cache_valid;
`else
    assign cache_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_INC, OP_DEC: state_nxt = cache_hit ? WR : RD;
                        OP_LOAD:        state_nxt = cache_hit ? FIN : RD;
                        OP_STORE:       state_nxt = WR;
                        default:        state_nxt = FIN;
                    endcase
                end
            end
            RD:      if (d_ack) state_nxt = (op == OP_LOAD) ? FIN : GAP;
            GAP:     state_nxt = WR;
            WR:      if (d_ack) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; request lines follow the state being entered
    always_comb begin
        op_nxt      = op;
        dptr_nxt    = dptr;
        rdata_nxt   = rdata;
        d_wdata_nxt = d_wdata;
        d_req_nxt   = (state_nxt == RD) || (state_nxt == WR);
        d_dir_nxt   = (state_nxt == WR) ? `DIRECTION_WRITE : `DIRECTION_READ;
        d_addr_nxt  = d_req_nxt ? dptr : d_addr;
        done_nxt    = (state_nxt == FIN);
        case (state)
            IDLE: begin
                if (accept) begin
                    op_nxt = cmd_op;
                    case (cmd_op)
                        OP_STORE: d_wdata_nxt = cmd_wdata;
                        OP_INC, OP_DEC: begin
                            if (cache_hit) d_wdata_nxt = cell_step(rdata, cmd_op == OP_DEC);
                        end
                        OP_RIGHT: dptr_nxt = (dptr == PTR_LAST) ? '0 : dptr + PTR_ONE;
                        OP_LEFT:  dptr_nxt = (dptr == '0) ? PTR_LAST : dptr - PTR_ONE;
                        default: ;
                    endcase
                end
            end
            RD:  if (d_ack) rdata_nxt = d_rdata;
            GAP: d_wdata_nxt = cell_step(rdata, op == OP_DEC);
            WR:  if (d_ack) rdata_nxt = d_wdata;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op      <= OP_NOP;
            dptr    <= '0;
            rdata   <= 8'd0;
            done    <= 1'b0;
            d_req   <= 1'b0;
            d_dir   <= `DIRECTION_READ;
            d_addr  <= '0;
            d_wdata <= 8'd0;
        end else begin
            op      <= op_nxt;
            dptr    <= dptr_nxt;
            rdata   <= rdata_nxt;
            done    <= done_nxt;
            d_req   <= d_req_nxt;
            d_dir   <= d_dir_nxt;
            d_addr  <= d_addr_nxt;
            d_wdata <= d_wdata_nxt;
        end
    end

endmodule

// File: tb/tb_bf_data_port.sv
// tb_bf_data_port: random command stream against a cell-array reference model,
// with a req/ack memory responder of configurable acknowledge latency.
`timescale 1ns/1ps
module tb_bf_data_port;
    localparam int AW = 8;
    localparam int ML = 64;
`ifdef BF_DATA_CELL_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic [2:0]    cmd_op;
    logic [7:0]    cmd_wdata;
    logic          cmd_ready, done, cell_zero;
    logic [7:0]    rdata;
    logic [AW-1:0] dptr;
    logic          d_req, d_dir, d_ack;
    logic [AW-1:0] d_addr;
    logic [7:0]    d_wdata, d_rdata;

    always #5 clk = ~clk;

    bf_data_port #(.d_addr_width(AW), .d_mem_length(ML)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_wdata(cmd_wdata), .cmd_ready(cmd_ready), .done(done), .rdata(rdata),
        .cell_zero(cell_zero), .dptr(dptr), .d_req(d_req), .d_dir(d_dir),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata)
    );

    // Memory responder: acknowledges in the ack_lat-th cycle of a request
    logic [7:0]    mem [0:255];
    int            ack_lat = 2;
    int            req_age = 0;
    int            rd_cnt = 0, wr_cnt = 0, proto_err = 0;
    bit            mem_ready = 1'b0, pending = 1'b0, acked = 1'b0;
    logic [AW-1:0] hold_addr;
    logic          hold_dir;
    logic [7:0]    hold_wdata;

    function automatic logic [7:0] init_val(input int i);
        if (i == 0 || i == 6) return 8'h00;
        return 8'(i * 37 + 11);
    endfunction

    assign d_ack   = d_req && (req_age >= ack_lat - 1);
    assign d_rdata = mem[d_addr];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end
        req_age <= d_req ? req_age + 1 : 0;
        if ((pending && (!d_req || d_addr != hold_addr || d_dir != hold_dir || d_wdata != hold_wdata)) ||
            (acked && d_req))
            proto_err <= proto_err + 1;
        pending    <= d_req && !d_ack && rst_n;
        acked      <= d_req && d_ack;
        hold_addr  <= d_addr;
        hold_dir   <= d_dir;
        hold_wdata <= d_wdata;
        if (d_req && d_ack) begin
            if (d_dir) begin
                mem[d_addr] <= d_wdata;
                wr_cnt      <= wr_cnt + 1;
            end else begin
                rd_cnt <= rd_cnt + 1;
            end
        end
    end

    // Reference model: a plain cell array, a pointer and the last cell value seen
    logic [7:0] ref_mem [0:ML-1];
    int         ref_dptr;
    logic [7:0] ref_rdata;
    bit         ref_cache;
    int         checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [7:0] wd);
        int  rd0, wr0, n, reads, writes, exp_lat;
        bit  seen;
        reads  = 0;
        writes = 0;
        case (op)
            3'd0, 3'd1: begin
                reads = (CACHE && ref_cache) ? 0 : 1;
                writes = 1;
                ref_mem[ref_dptr] = (op == 3'd0) ? ref_mem[ref_dptr] + 8'd1 : ref_mem[ref_dptr] - 8'd1;
                ref_rdata = ref_mem[ref_dptr];
                ref_cache = 1'b1;
            end
            3'd2: begin ref_dptr = (ref_dptr + 1) % ML; ref_cache = 1'b0; end
            3'd3: begin ref_dptr = (ref_dptr + ML - 1) % ML; ref_cache = 1'b0; end
            3'd4: begin
                reads = (CACHE && ref_cache) ? 0 : 1;
                ref_rdata = ref_mem[ref_dptr];
                ref_cache = 1'b1;
            end
            3'd5: begin
                writes = 1;
                ref_mem[ref_dptr] = wd;
                ref_rdata = wd;
                ref_cache = 1'b1;
            end
            default: ;
        endcase
        exp_lat = 2 + ack_lat * (reads + writes) + ((reads != 0 && writes != 0) ? 1 : 0);

        chk("cmd_ready", 32'(cmd_ready), 32'd1);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_wdata = wd;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_wdata = 8'($urandom);
        n = 1;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        if (seen) chk("latency", 32'(n), 32'(exp_lat));
        chk("rdata", 32'(rdata), 32'(ref_rdata));
        chk("cell_zero", 32'(cell_zero), 32'(ref_rdata == 8'd0));
        chk("dptr", 32'(dptr), 32'(ref_dptr));
        chk("reads", 32'(rd_cnt - rd0), 32'(reads));
        chk("writes", 32'(wr_cnt - wr0), 32'(writes));
        chk("mem_cell", 32'(mem[ref_dptr]), 32'(ref_mem[ref_dptr]));
        chk("protocol", 32'(proto_err), 32'd0);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n, old_ptr;
        bit  seen;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_wdata = 8'd0;
        for (int i = 0; i < ML; i++) ref_mem[i] = init_val(i);
        ref_dptr  = 0;
        ref_rdata = 8'd0;
        ref_cache = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_d_req", 32'(d_req), 32'd0);
        chk("rst_d_dir", 32'(d_dir), 32'd0);
        chk("rst_d_addr", 32'(d_addr), 32'd0);
        chk("rst_d_wdata", 32'(d_wdata), 32'd0);
        chk("rst_dptr", 32'(dptr), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_cell_zero", 32'(cell_zero), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd(3'd4, 8'h00);
        run_cmd(3'd5, 8'hFF);
        run_cmd(3'd0, 8'h00);
        run_cmd(3'd3, 8'h00);
        run_cmd(3'd2, 8'h00);
        repeat (5) run_cmd(3'd2, 8'h00);
        run_cmd(3'd5, 8'h41);
        run_cmd(3'd4, 8'h00);
        run_cmd(3'd2, 8'h00);
        ack_lat = 6;
        run_cmd(3'd1, 8'h00);
        ack_lat = 2;
        run_cmd(3'd6, 8'h00);
        run_cmd(3'd7, 8'h00);

        for (int k = 0; k < 150; k++) begin
            ack_lat = $urandom_range(1, 4);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_cmd(3'($urandom_range(0, 7)), 8'($urandom));
        end

        // Reset while a write is outstanding
        ack_lat = 2;
        run_cmd(3'd2, 8'h00);
        old_ptr = ref_dptr;
        ack_lat = 8;
        cmd_valid = 1'b1;
        cmd_op    = 3'd0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        n = 0;
        while (!(d_req && d_dir) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach_wr", 32'(d_req && d_dir), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_d_req", 32'(d_req), 32'd0);
        chk("abort_idle", 32'(cmd_ready), 32'd1);
        chk("abort_dptr", 32'(dptr), 32'd0);
        chk("abort_rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        chk("abort_mem", 32'(mem[old_ptr]), 32'(ref_mem[old_ptr]));
        ref_dptr  = 0;
        ref_rdata = 8'd0;
        ref_cache = 1'b0;
        ack_lat   = 2;
        run_cmd(3'd4, 8'h00);
        run_cmd(3'd0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
